// File: rtl/step_clock_ctrl_pkg.sv
// Shared definitions for the step clock controller: FSM encoding,
// step counter width and a small constant helper.
package step_clock_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_RUN        = 3'd1,
    ST_STEP_IDLE  = 3'd2,
    ST_STEP_PULSE = 3'd3,
    ST_HALT       = 3'd4
  } state_t;

  localparam int STEP_COUNT_W = 16;

  // Smaller of two integers, used for elaboration-time constants.
  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/step_clock_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on each debounced 0->1 transition.
module step_clock_ctrl_btn_debounce
  import step_clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = {DEBOUNCE_BITS{1'b1}};

  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_level;
  logic [DEBOUNCE_BITS-1:0] r_cnt;
  logic                     r_press;

  // Synchronize, count consecutive disagreeing samples, update level and emit press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        // any agreeing sample restarts the stability window
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        // 2^DEBOUNCE_BITS consecutive disagreeing samples: accept new level
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + DEBOUNCE_BITS'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/step_clock_ctrl.sv
// Processor clock/reset generator: divided free-running clock or single-step
// pulses selected by debounced buttons, frozen once the processor is done.
module step_clock_ctrl
  import step_clock_ctrl_pkg::*;
#(
  parameter int DIV_BITS      = 24,
  parameter int DEBOUNCE_BITS = 20,
  parameter int STEP_HIGH     = 1024,
  parameter int RESET_HOLD    = 4,
  parameter int STOP_ON_DONE  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_mode,
  input  logic                    btn_step,
  input  logic                    done,
  output logic                    clk_out,
  output logic                    reset_out,
  output logic                    running,
  output logic [STEP_COUNT_W-1:0] step_count
);

  // Shortest legal clk_out phase; step pulses are held off until the low
  // phase has lasted at least this long.
  localparam int MIN_PHASE = min_int(2 ** (DIV_BITS - 1), STEP_HIGH);
  localparam int LOW_W     = $clog2(MIN_PHASE + 1);
  localparam int PULSE_W   = $clog2(STEP_HIGH);
  localparam int HOLD_W    = $clog2(RESET_HOLD + 1);

  state_t                  r_state;
  logic [DIV_BITS-1:0]     r_div_cnt;
  logic [HOLD_W-1:0]       r_hold_cnt;
  logic [PULSE_W-1:0]      r_pulse_cnt;
  logic [LOW_W-1:0]        r_low_cnt;
  logic                    r_mode_pend;
  logic                    r_clk_out;
  logic                    r_reset_out;
  logic                    r_running;
  logic [STEP_COUNT_W-1:0] r_step_count;
  logic                    r_done_s1;
  logic                    r_done_s;

  state_t                  w_state_nxt;
  logic [DIV_BITS-1:0]     w_div_nxt;
  logic [HOLD_W-1:0]       w_hold_nxt;
  logic [PULSE_W-1:0]      w_pulse_nxt;
  logic                    w_pend_nxt;
  logic                    w_clk_nxt;
  logic                    w_rst_out_nxt;
  logic                    w_mode_press;
  logic                    w_step_press;
  logic                    w_low_ok;
  logic                    w_stop;

  step_clock_ctrl_btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_mode (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_btn   (btn_mode),
    .o_press (w_mode_press)
  );

  step_clock_ctrl_btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_step (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_btn   (btn_step),
    .o_press (w_step_press)
  );

  assign w_low_ok = (r_low_cnt == LOW_W'(MIN_PHASE));
  assign w_stop   = (STOP_ON_DONE != 0) && r_done_s;

  // Next-state and next-output decode for the clock FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_pulse_nxt   = r_pulse_cnt;
    w_pend_nxt    = 1'b0;
    w_clk_nxt     = 1'b0;
    w_rst_out_nxt = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
          w_state_nxt = ST_RUN;
          w_hold_nxt  = '0;
          w_div_nxt   = '0;
        end else begin
          w_hold_nxt    = r_hold_cnt + HOLD_W'(1);
          w_rst_out_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        w_div_nxt  = r_div_cnt + DIV_BITS'(1);
        w_clk_nxt  = w_div_nxt[DIV_BITS-1];
        w_pend_nxt = r_mode_pend | w_mode_press;
        if (w_div_nxt == '0) begin
          // wrap point = falling edge of clk_out: the only place RUN may exit
          if (w_stop) begin
            w_state_nxt = ST_HALT;
            w_pend_nxt  = 1'b0;
          end else if (w_pend_nxt) begin
            w_state_nxt = ST_STEP_IDLE;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STEP_IDLE: begin
        if (w_stop) begin
          w_state_nxt = ST_HALT;
        end else if (w_mode_press) begin
          // mode wins over a simultaneous step press
          w_state_nxt = ST_RUN;
          w_div_nxt   = '0;
        end else if (w_step_press && w_low_ok) begin
          w_state_nxt = ST_STEP_PULSE;
          w_pulse_nxt = '0;
          w_clk_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_STEP_IDLE;
        end
      end
      ST_STEP_PULSE: begin
        if (r_pulse_cnt == PULSE_W'(STEP_HIGH - 1)) begin
          w_state_nxt = ST_STEP_IDLE;
          w_pulse_nxt = '0;
        end else begin
          w_pulse_nxt = r_pulse_cnt + PULSE_W'(1);
          w_clk_nxt   = 1'b1;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt   = ST_HOLD;
        w_rst_out_nxt = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs; async reset forces safe values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_HOLD;
      r_div_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_pulse_cnt  <= '0;
      r_low_cnt    <= '0;
      r_mode_pend  <= 1'b0;
      r_clk_out    <= 1'b0;
      r_reset_out  <= 1'b1;
      r_running    <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_div_cnt   <= w_div_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_pulse_cnt <= w_pulse_nxt;
      r_mode_pend <= w_pend_nxt;
      r_clk_out   <= w_clk_nxt;
      r_reset_out <= w_rst_out_nxt;
      r_running   <= (w_state_nxt == ST_RUN);
      if (w_clk_nxt && !r_clk_out) begin
        r_step_count <= r_step_count + STEP_COUNT_W'(1);
      end else begin
        r_step_count <= r_step_count;
      end
      if (w_clk_nxt) begin
        r_low_cnt <= '0;
      end else if (!w_low_ok) begin
        r_low_cnt <= r_low_cnt + LOW_W'(1);
      end else begin
        r_low_cnt <= r_low_cnt;
      end
    end
  end

  // Two-flop synchronizer for the processor-domain done flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_s1 <= 1'b0;
      r_done_s  <= 1'b0;
    end else begin
      r_done_s1 <= done;
      r_done_s  <= r_done_s1;
    end
  end

  assign clk_out    = r_clk_out;
  assign reset_out  = r_reset_out;
  assign running    = r_running;
  assign step_count = r_step_count;

endmodule

// File: doc/step_clock_ctrl.md
Name: step_clock_ctrl

Overview:
- Board-level clock controller that sits directly upstream of the Processor.
- Produces the processor clock and processor reset from the 100 MHz board clock.
- Supports free-running divided-clock mode and single-step mode, selected from debounced push-buttons.
- Freezes the processor clock once the processor reports done; also counts delivered processor clock edges for debug display.

Parameters:
DIV_BITS, 24, run-mode divider width; clk_out period = 2^DIV_BITS clk cycles
DEBOUNCE_BITS, 20, debounce counter width; input must be stable 2^DEBOUNCE_BITS cycles
STEP_HIGH, 1024, clk cycles clk_out stays high per single-step pulse (>=2)
RESET_HOLD, 4, clk cycles reset_out stays high after reset deasserts (>=1)
STOP_ON_DONE, 1, 1 = halt clock when done seen in run mode

Ports:
clk  input  1  board clock; all state on its rising edge
reset  input  1  asynchronous, active-high reset
btn_mode  input  1  raw push-button; a press toggles RUN/STEP
btn_step  input  1  raw push-button; a press issues one processor clock in STEP
done  input  1  processor done flag (processor clock domain)
clk_out  output  1  processor clock, registered, glitch-free
reset_out  output  1  processor reset, active-high
running  output  1  1 only in RUN state
step_count  output  16  count of clk_out rising edges since reset, wraps

Behaviour:
- Reset values: clk_out=0, reset_out=1, running=0, step_count=0, state=HOLD, all counters 0, debounced button states 0.
- reset asserts reset_out immediately (async).
- Button path, per button: 2-flop synchronizer; debounced state updates only after the synchronized value differs from it for 2^DEBOUNCE_BITS consecutive cycles. Any agreeing sample clears the counter.
- Press = one-cycle pulse on debounced 0->1; a release generates nothing.
- done: 2-flop synchronizer to done_s.
- States:
  - HOLD: clk_out=0; hold counter counts RESET_HOLD cycles after reset release; reset_out drops synchronously on the exit cycle; next state RUN. Button presses are ignored.
  - RUN: divider counter increments every cycle; clk_out <= counter[DIV_BITS-1] (first rising edge 2^(DIV_BITS-1) cycles after entry).
    - Mode press is latched as pending; it is taken when the counter wraps to 0 (clk_out falling). Then go to STEP_IDLE and clear the counter.
    - If STOP_ON_DONE and done_s=1, go to HALT at the same wrap point. Done has priority over a pending mode press.
  - STEP_IDLE: clk_out=0.
    - Step press -> STEP_PULSE, clk_out=1 next cycle.
    - Mode press -> RUN with counter cleared.
    - Simultaneous presses: mode wins, step is dropped.
    - done_s with STOP_ON_DONE -> HALT.
  - STEP_PULSE: clk_out=1 for exactly STEP_HIGH cycles, then 0, then STEP_IDLE. Presses during the pulse are ignored (not queued).
  - HALT: clk_out=0 permanently; all presses ignored; exit only via reset.
- running=1 only in RUN.
- step_count increments on every cycle where clk_out goes 0->1, in both modes; 16-bit wrap 0xFFFF->0.
- clk_out never produces a high or low phase shorter than min(2^(DIV_BITS-1), STEP_HIGH) cycles, including across mode changes.
- Reset mid-pulse: clk_out and reset_out take their reset values immediately; the state machine re-enters HOLD.

Decomposition:
- Shared package: state encoding (HOLD, RUN, STEP_IDLE, STEP_PULSE, HALT) and the STEP_COUNT_W=16 constant.
- One sub-module, btn_debounce (sync + counter + rise pulse, parameter DEBOUNCE_BITS), instantiated twice.
- done synchronizer and FSM stay inline.

Test Plan:
All scenarios use DIV_BITS=4, DEBOUNCE_BITS=3, STEP_HIGH=4, RESET_HOLD=4.
1. Release reset -> reset_out high 4 cycles then low; clk_out period 16 cycles (8 high/8 low); step_count=3 after 3 rising edges.
2. Hold btn_mode high 5 cycles, then 9 cycles -> first ignored (bounce), second yields one press; clk_out finishes its high phase, then stays 0; running=0.
3. In STEP_IDLE, one clean step press -> exactly one clk_out high of 4 cycles; step_count +1; a second press during the pulse produces no extra edge.
4. Mode and step pressed on the same cycle in STEP_IDLE -> RUN entered, no step pulse, first clk_out rise 8 cycles later.
5. done=1 while clk_out high in RUN -> clk_out completes its high phase, falls at wrap, stays 0; further presses ignored; step_count frozen.
6. Assert reset during a STEP_PULSE high phase -> clk_out=0 and reset_out=1 in the same cycle; step_count=0; HOLD sequence repeats.
